// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised synchronous FIFO:
//   - clog2()            : ceiling log2, used to size pointers and the count
//   - fifo_err_t         : sticky error flag pair {overflow, underflow}
//   - FIFO_DEFAULT_WIDTH : default data word width
//   - FIFO_DEFAULT_DEPTH : default number of entries
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DEFAULT_WIDTH = 32;
  localparam int FIFO_DEFAULT_DEPTH = 128;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Number of bits needed to encode values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage : fifo_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Simple dual-port storage array for sync_fifo_param: DEPTH x WIDTH,
// synchronous write port and asynchronous (combinational) read port.
// Both the first-word-fall-through and registered read stages of the FIFO
// are built on the single read port.
// Ports:
//   clk        in   rising-edge clock
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write address (AW bits)
//   wr_data_i  in   write data (WIDTH bits)
//   rd_addr_i  in   read address (AW bits)
//   rd_data_o  out  contents at rd_addr_i (WIDTH bits)
// -----------------------------------------------------------------------------
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH = FIFO_DEFAULT_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; occupancy is tracked by pointers and count,
  // so stale contents are never observed and the array can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO used to decouple pipeline stages
// (fetch->decode queue, store buffer). Any DEPTH >= 2 (not necessarily a power
// of two), exact occupancy count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a synchronous flush.
//
// Build option:
//   SYNC_FIFO_FWFT_EN defined   : first-word-fall-through; rd_data shows the
//                                 head whenever non-empty, rd_valid = !empty.
//   SYNC_FIFO_FWFT_EN undefined : registered read; an accepted read loads
//                                 rd_data and pulses rd_valid for one cycle.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   flush         in   synchronous clear of contents and error flags
//   wr_en         in   write request
//   wr_data       in   write data (WIDTH)
//   rd_en         in   read request
//   rd_data       out  read data (WIDTH)
//   rd_valid      out  rd_data carries a valid word
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  occupancy (CW = clog2(DEPTH+1) bits)
//   overflow      out  sticky: write attempted while full
//   underflow     out  sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int WIDTH    = FIFO_DEFAULT_WIDTH,
  parameter  int DEPTH    = FIFO_DEFAULT_DEPTH,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  localparam int CW       = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            AW        = clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C      = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C      = CW'(AE_LEVEL);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  fifo_err_t        err_q, err_d;
  logic             wr_accept, rd_accept;
  logic [WIDTH-1:0] head_data;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
  endfunction

  // Flags decode straight from the registered count.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

  // Acceptance uses start-of-cycle flags: no write-through when full,
  // no read-through when empty.
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_accept && !flush),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_data)
  );

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through this block leaves one unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = '0;
    end else begin
      if (wr_accept) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_accept) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      err_d.overflow  = err_q.overflow  | (wr_en && full);
      err_d.underflow = err_q.underflow | (rd_en && empty);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly from the array read port.
  assign rd_data  = empty ? '0 : head_data;
  assign rd_valid = !empty;
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (!flush && rd_accept) begin
      rd_data_d  = head_data;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule : sync_fifo_param
